// File: rtl/fsm_check_ctrl_if.sv
// fsm_check_ctrl_if: run control, detector stimulus/response and result bundle for the self-check sequencer
interface fsm_check_ctrl_if #(parameter int PAT_LEN = 16, parameter int CNT_W = 8);
  logic start;
  logic [PAT_LEN-1:0] pattern;
  logic q_mealy;
  logic q_moore;
  logic x;
  logic fsm_reset;
  logic busy;
  logic done;
  logic [CNT_W-1:0] err_count;
  logic pass;
  modport master (output start, pattern, q_mealy, q_moore, input x, fsm_reset, busy, done, err_count, pass);
  modport slave (input start, pattern, q_mealy, q_moore, output x, fsm_reset, busy, done, err_count, pass);
endinterface

// File: rtl/fsm_check_ctrl.sv
// fsm_check_ctrl: Mealy/Moore detector self-check sequencer; FSM_CHECK_STOP_ON_ERR_EN ends a run at the first mismatch
module fsm_check_ctrl #(
  parameter int PAT_LEN = 16,
  parameter int CNT_W = 8
) (
  input logic clk,
  input logic reset,
  fsm_check_ctrl_if.slave bus
);
  localparam int IW = $clog2(PAT_LEN);
  typedef enum logic [2:0] {IDLE, LOAD, DRIVE, FLUSH, DONE} state_t;
  state_t state_q, state_d;
  logic [PAT_LEN-1:0] sr_q, sr_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic x_q, x_d;
  logic fsm_reset_q, fsm_reset_d;
  logic mealy_dly_q, mealy_dly_d;
  logic pass_q, pass_d;
  logic last, cmp, mism;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sr_q <= '0;
      idx_q <= '0;
      err_q <= '0;
      x_q <= 1'b0;
      fsm_reset_q <= 1'b1;
      mealy_dly_q <= 1'b0;
      pass_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q <= sr_d;
      idx_q <= idx_d;
      err_q <= err_d;
      x_q <= x_d;
      fsm_reset_q <= fsm_reset_d;
      mealy_dly_q <= mealy_dly_d;
      pass_q <= pass_d;
    end
  end
  // The Moore output trails the Mealy output by one cycle, so it is compared against the delayed Mealy sample
  assign last = idx_q == IW'(PAT_LEN - 1);
  assign cmp = (state_q == DRIVE && idx_q != '0) || state_q == FLUSH;
  assign mism = cmp && (bus.q_moore != mealy_dly_q);
  always_comb begin
    state_d = state_q == IDLE  ? (bus.start ? LOAD : IDLE)
            : state_q == LOAD  ? DRIVE
            : state_q == DRIVE ? (last ? FLUSH : DRIVE)
            : state_q == FLUSH ? DONE
            : IDLE;
`ifdef FSM_CHECK_STOP_ON_ERR_EN
    if (mism) state_d = DONE;
`endif
  end
  // x is precomputed from the next shift-register value so it leaves a flop in step with the state
  always_comb begin
    sr_d = state_q == LOAD ? bus.pattern : state_q == DRIVE ? sr_q >> 1 : sr_q;
    idx_d = state_q == LOAD ? '0 : state_q == DRIVE ? idx_q + IW'(1) : idx_q;
    mealy_dly_d = state_q == LOAD ? 1'b0 : state_q == DRIVE ? bus.q_mealy : mealy_dly_q;
    err_d = state_q == LOAD ? '0 : (mism && err_q != '1) ? err_q + CNT_W'(1) : err_q;
    pass_d = state_q == LOAD ? 1'b0 : state_d == DONE ? err_d == '0 : pass_q;
    x_d = state_d == DRIVE && sr_d[0];
    fsm_reset_d = state_d == LOAD;
  end
  always_comb begin
    bus.busy = state_q == LOAD || state_q == DRIVE || state_q == FLUSH;
    bus.done = state_q == DONE;
    bus.x = x_q;
    bus.fsm_reset = fsm_reset_q;
    bus.err_count = err_q;
    bus.pass = pass_q;
  end
endmodule

// File: tb/tb_fsm_check_ctrl.sv
// tb_fsm_check_ctrl: directed self-check of fsm_check_ctrl against a "11" Mealy/Moore detector pair
module tb_fsm_check_ctrl;
`ifdef FSM_CHECK_STOP_ON_ERR_EN
  localparam int LAT_MM = 4;
  localparam int ERR_MM = 1;
  localparam int SAT_EXP = 1;
  localparam bit ABORT_TIE = 1'b0;
`else
  localparam int LAT_MM = 19;
  localparam int ERR_MM = 16;
  localparam int SAT_EXP = 7;
  localparam bit ABORT_TIE = 1'b1;
`endif
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic tie_err = 1'b0;
  logic sat_mon = 1'b0;
  logic det_prev_q, moore_q;
  int n_checks = 0;
  int n_errors = 0;
  int lat, nres, ndone;
  logic [15:0] xs;
  always #5 clk = ~clk;
  fsm_check_ctrl_if #(.PAT_LEN(16), .CNT_W(8)) bus ();
  fsm_check_ctrl_if #(.PAT_LEN(16), .CNT_W(3)) bus3 ();
  fsm_check_ctrl #(.PAT_LEN(16), .CNT_W(8)) dut (.clk(clk), .reset(reset), .bus(bus));
  fsm_check_ctrl #(.PAT_LEN(16), .CNT_W(3)) dut3 (.clk(clk), .reset(reset), .bus(bus3));
  always_ff @(posedge clk) begin
    det_prev_q <= bus.fsm_reset ? 1'b0 : bus.x;
    moore_q <= bus.fsm_reset ? 1'b0 : det_prev_q & bus.x;
  end
  always_comb begin
    bus.q_mealy = tie_err ? 1'b0 : det_prev_q & bus.x;
    bus.q_moore = tie_err ? 1'b1 : moore_q;
  end
  assign bus3.start = bus.start;
  assign bus3.pattern = bus.pattern;
  assign bus3.q_mealy = 1'b0;
  assign bus3.q_moore = 1'b1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts from IDLE and returns in the DONE cycle (or after a 40-cycle bound); lat counts cycles from the start edge
  task automatic run(input int pulse_at, input bit hold);
    lat = 0;
    xs = '0;
    nres = 0;
    bus.start = 1'b1;
    tick();
    lat = 1;
    if (!hold) bus.start = 1'b0;
    while (!bus.done && lat < 40) begin
      if (bus.fsm_reset) nres++;
      if (lat >= 2 && lat <= 17) xs[lat-2] = bus.x;
      if (sat_mon && lat >= 10) check("sat_run", bus3.err_count, SAT_EXP);
      if (!hold) bus.start = lat == pulse_at;
      tick();
      lat++;
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.pattern = '0;
    repeat (4) tick();
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_x", bus.x, 0);
    check("rst_fsm_reset", bus.fsm_reset, 1);
    check("rst_err", bus.err_count, 0);
    check("rst_pass", bus.pass, 0);
    reset = 1'b0;
    tick();
    check("idle_fsm_reset", bus.fsm_reset, 0);

    bus.pattern = 16'h6C36;
    run(-1, 1'b0);
    check("match_lat", lat, 19);
    check("match_nres", nres, 1);
    check("match_xseq", xs, 16'h6C36);
    check("match_err", bus.err_count, 0);
    check("match_pass", bus.pass, 1);
    tick();
    check("match_done_pulse", bus.done, 0);
    check("match_pass_hold", bus.pass, 1);

    bus.pattern = 16'hA5C3;
    run(7, 1'b0);
    check("pulse_lat", lat, 19);
    check("pulse_xseq", xs, 16'hA5C3);
    check("pulse_err", bus.err_count, 0);
    ndone = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.done || bus.busy) ndone++;
    end
    check("pulse_ignored", ndone, 0);

    tie_err = 1'b1;
    sat_mon = 1'b1;
    run(-1, 1'b0);
    sat_mon = 1'b0;
    check("mm_lat", lat, LAT_MM);
    check("mm_err", bus.err_count, ERR_MM);
    check("mm_pass", bus.pass, 0);
    check("sat_done", bus3.err_count, SAT_EXP);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("sat_hold", bus3.err_count, SAT_EXP);
    end

    tie_err = ABORT_TIE;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 2; i <= 10; i++) tick();
    check("abort_pre_busy", bus.busy, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_busy", bus.busy, 0);
    check("abort_x", bus.x, 0);
    check("abort_err", bus.err_count, 0);
    check("abort_fsm_reset", bus.fsm_reset, 1);
    check("abort_pass", bus.pass, 0);
    ndone = 0;
    for (int i = 0; i < 25; i++) begin
      if (bus.done || bus.busy) ndone++;
      tick();
    end
    check("abort_no_done", ndone, 0);

    tie_err = 1'b1;
    run(-1, 1'b1);
    check("b2b_lat", lat, LAT_MM);
    check("b2b_err", bus.err_count, ERR_MM);
    tick();
    check("b2b_idle_busy", bus.busy, 0);
    check("b2b_idle_err", bus.err_count, ERR_MM);
    tick();
    check("b2b_load_busy", bus.busy, 1);
    check("b2b_load_fsm_reset", bus.fsm_reset, 1);
    bus.start = 1'b0;
    for (int i = 0; i < 40 && !bus.done; i++) tick();
    check("b2b_done2", bus.done, 1);
    check("b2b_err2", bus.err_count, ERR_MM);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/fsm_check_ctrl.md
# fsm_check_ctrl

Self-check sequencer for the Mealy/Moore sequence-detector pair.
- On `start`, resets both detectors, then shifts a programmed bit pattern into their shared `X` input, one bit per clock.
- Compares the two `Q` outputs with the one-cycle Moore lag removed, counts mismatches and reports pass/fail.
- Replaces bench-only stimulus with a synthesizable controller that owns the detectors' `X` and reset.

## Interface
Parameters:
- `PAT_LEN`, 16: pattern length in bits, ≥2.
- `CNT_W`, 8: mismatch counter width, ≥1.

Ports:
- `clk`  in  1  single clock. All logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  run request; sampled only in IDLE.
- `pattern`  in  PAT_LEN  stimulus bits, driven LSB first; latched in LOAD.
- `q_mealy`  in  1  Mealy detector output.
- `q_moore`  in  1  Moore detector output.
- `x`  out  1  shared `X` input to both detectors.
- `fsm_reset`  out  1  synchronous active-high reset to both detectors.
- `busy`  out  1  high in LOAD, DRIVE and FLUSH.
- `done`  out  1  one-cycle pulse in DONE.
- `err_count`  out  CNT_W  mismatch count; saturating.
- `pass`  out  1  `err_count == 0`, valid from DONE onward.

## Operation
States: IDLE, LOAD, DRIVE, FLUSH, DONE.
- IDLE: `x=0`, `fsm_reset=0`. `start=1` → LOAD.
- LOAD (1 cycle):
  - `fsm_reset=1`, `x=0`.
  - `sr<=pattern`, `idx<=0`, `err_count<=0`, `pass<=0`, `mealy_d<=0`.
  - → DRIVE.
- DRIVE (PAT_LEN cycles):
  - `x=sr[0]`; `sr` shifts right each cycle; `mealy_d<=q_mealy`; `idx` increments.
  - Compare active for idx 1..PAT_LEN-1.
  - → FLUSH after idx = PAT_LEN-1.
- FLUSH (1 cycle): `x=0`. Compares `q_moore` against `mealy_d`, which holds the Mealy output for the last pattern bit. → DONE.
- DONE (1 cycle):
  - `done=1`, `busy=0`, `pass<=(err_count==0)`.
  - → IDLE.
- Compare rule: in each compare cycle, `q_moore != mealy_d` increments `err_count`. Exactly PAT_LEN compares per run.
- `err_count` saturates at 2^CNT_W−1 and never wraps.
- `start` outside IDLE is ignored; it is not queued. `start` held high through DONE starts a new run from IDLE on the following cycle.
- `err_count` and `pass` hold their values from DONE until the next LOAD.
- `x` is registered, so there is no combinational path from any input to `x`.

## Timing
- Reset values: state IDLE, `x=0`, `fsm_reset=1` while `reset` is high, `busy=0`, `done=0`, `err_count=0`, `pass=0`.
- `reset` asserted mid-run: IDLE on the next edge, and all outputs take their reset values on the next edge. No `done` pulse is emitted for an aborted run.
- Latency, with `start` sampled at edge E:
  - LOAD in cycle E+1.
  - First pattern bit on `x` in cycle E+2.
  - FLUSH in cycle E+PAT_LEN+2.
  - `done` high in cycle E+PAT_LEN+3.
- The earliest next `start` is accepted at the edge ending the IDLE cycle after DONE.
- Simultaneous `reset` and `start`: `reset` wins.
- The saturating increment and the compare in the same cycle resolve to the saturated value.

## Configuration
- `FSM_CHECK_STOP_ON_ERR_EN` defined: the first mismatch in DRIVE or FLUSH moves the FSM to DONE on the next edge.
  - `err_count=1`, `pass=0`.
  - `x` is driven 0 from that edge.
  - `done` arrives earlier than E+PAT_LEN+3.
- Undefined: every run executes all PAT_LEN compares and counts every mismatch.

## Test plan
- Matching detector models, PAT_LEN=16, `pattern=16'h6C36` → `done` exactly 19 cycles after `start` edge; `err_count=0`, `pass=1`; `fsm_reset` high for one cycle, in LOAD.
- `q_moore` tied 1, `q_mealy` tied 0, PAT_LEN=16 → `err_count=16`, `pass=0`; with the macro defined, `err_count=1` and `done` in cycle E+4.
- CNT_W=3, PAT_LEN=16, every compare mismatching → `err_count` stops at 7 and never reads 0 afterwards.
- `start` pulsed in DRIVE cycle 5 → ignored; single `done`; `x` sequence equals `pattern` LSB first.
- `reset` raised in DRIVE cycle 8 → next cycle state IDLE, `x=0`, `busy=0`, `err_count=0`, `fsm_reset=1`; no `done` pulse.
- Back-to-back runs, `start` held high: second LOAD in cycle E+PAT_LEN+5; `err_count` from the first run held until then.
